// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs 4 bytes per word (big-endian) and holds the CPU until loaded.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit checksum check (CHECK state, chk_sum port).
//
// state | meaning
// IDLE  | after reset, waiting for start; CPU held
// LOAD  | accepting bytes of the current word
// WRITE | one-cycle write of the assembled word
// CHECK | accepting the 4 expected-checksum bytes (checksum build only)
// DONE  | program loaded, CPU released
// ERROR | overflow or checksum mismatch; CPU held until start or rst
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              done,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]       chk_sum,
`endif
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
  logic [23:0]       exp_q, exp_d;
`endif

  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                 input logic [1:0] k,
                                                 input logic [7:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    exp_d   = exp_q;
    byte_ready = (state_q == LOAD) || (state_q == CHECK);
`else
    byte_ready = (state_q == LOAD);
`endif
    accept = byte_valid && byte_ready;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          wdata_d = put_byte(wdata_q, cnt_q, byte_data);
          cnt_d   = cnt_q + 2'd1;
          last_d  = byte_last;
          if (byte_last || (cnt_q == 2'd3)) state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + wdata_q[31:0];
`endif
        cnt_d = '0;
        if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else if (&addr_q[ADDR_W-1:2]) begin
          // top word just written and the stream is still going
          state_d = ERROR;
        end else begin
          addr_d  = addr_q + ADDR_W'(4);
          wdata_d = '0;
          state_d = LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: exp_d[23:16] = byte_data;
            2'd1: exp_d[15:8]  = byte_data;
            2'd2: exp_d[7:0]   = byte_data;
            default: state_d = ({exp_q, byte_data} == sum_q) ? DONE : ERROR;
          endcase
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      exp_q   <= exp_d;
`endif
    end
  end

  assign im_we    = (state_q == WRITE);
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_hold = (state_q != DONE);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_sum  = sum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum steps run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst, start, byte_valid, byte_last;
  logic [7:0]  byte_data;
  logic        byte_ready, im_we, cpu_hold, done, err;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] chk_sum;
`endif

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int base;
  logic [7:0]  last_wa;
  logic [31:0] last_wd;

  imem_loader #(.ADDR_W(8), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .chk_sum(chk_sum),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // write log, sampled mid-cycle
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = im_addr;
      last_wd = im_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = l;
    for (int i = 0; i < 20; i++) begin
      if (byte_ready === 1'b1) begin
        tick();
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $error("FAIL byte_accept_timeout observed=%h expected=accepted", b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b1; byte_last = 1'b0; byte_data = 8'h5A;

    // reset with a byte pending
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_im_we", im_we, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_im_addr", im_addr, 0);
      chk("rst_im_wdata", im_wdata, 0);
    end
    rst = 1'b0;
    byte_valid = 1'b0;
    tick();
    chk("idle_byte_ready", byte_ready, 0);
    chk("idle_cpu_hold", cpu_hold, 1);

    // two-word load
    pulse_start();
    chk("load_byte_ready", byte_ready, 1);
    send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    chk("w0_im_we", im_we, 1);
    chk("w0_byte_ready", byte_ready, 0);
    chk("w0_addr", im_addr, 32'h00);
    chk("w0_data", im_wdata, 32'h20080005);
    send_byte(8'h01, 0); send_byte(8'h09, 0); send_byte(8'h50, 0); send_byte(8'h20, 1);
    chk("w1_im_we", im_we, 1);
    chk("w1_byte_ready", byte_ready, 0);
    chk("w1_addr", im_addr, 32'h04);
    chk("w1_data", im_wdata, 32'h01095020);
    byte_valid = 1'b0; byte_last = 1'b0;
    tick();
    chk("two_done", done, 1);
    chk("two_cpu_hold", cpu_hold, 0);
    chk("two_im_we_after", im_we, 0);
    chk("two_write_count", wr_cnt, 2);

    // short final word, reload from DONE
    pulse_start();
    chk("reload_cpu_hold", cpu_hold, 1);
    chk("reload_done_clr", done, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1);
    chk("short_im_we", im_we, 1);
    chk("short_addr", im_addr, 32'h00);
    chk("short_data", im_wdata, 32'hAABBCC00);
    byte_valid = 1'b0; byte_last = 1'b0;
    tick();
    chk("short_done", done, 1);
    chk("short_write_count", wr_cnt, 3);

    // overflow: 65th word never written
    base = wr_cnt;
    pulse_start();
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 4; b++)
        send_byte(8'(w * 4 + b), 1'b0);
    chk("ovf_last_addr", im_addr, 32'hFC);
    chk("ovf_last_we", im_we, 1);
    byte_data = 8'h77;
    tick();
    chk("ovf_err", err, 1);
    chk("ovf_cpu_hold", cpu_hold, 1);
    chk("ovf_byte_ready", byte_ready, 0);
    chk("ovf_done", done, 0);
    repeat (4) tick();
    chk("ovf_no_65th_write", wr_cnt - base, 64);
    chk("ovf_im_we_idle", im_we, 0);
    chk("ovf_err_sticky", err, 1);
    chk("ovf_last_logged_addr", last_wa, 32'hFC);
    chk("ovf_last_logged_data", last_wd, 32'hFCFDFEFF);

    // full 64-word image completes
    base = wr_cnt;
    pulse_start();
    chk("full_err_clr", err, 0);
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 4; b++)
        send_byte(8'(w * 4 + b), (w == 63) && (b == 3));
    chk("full_last_addr", im_addr, 32'hFC);
    byte_valid = 1'b0; byte_last = 1'b0;
    tick();
    chk("full_done", done, 1);
    chk("full_err", err, 0);
    chk("full_write_count", wr_cnt - base, 64);

    // backpressure, ignored start mid-load, then reset mid-word
    pulse_start();
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    chk("bp_w0_data", im_wdata, 32'hDEADBEEF);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    byte_valid = 1'b0;
    base = wr_cnt;
    repeat (3) tick();
    chk("bp_word_held", im_wdata, 32'h11220000);
    chk("bp_no_we", im_we, 0);
    chk("bp_ready", byte_ready, 1);
    pulse_start();
    chk("bp_start_ignored_addr", im_addr, 32'h04);
    chk("bp_start_ignored_data", im_wdata, 32'h11220000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_addr", im_addr, 0);
    chk("midrst_data", im_wdata, 0);
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_byte_ready", byte_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    tick();
    chk("midrst_no_write", wr_cnt - base, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h02, 1);
    tick();
    chk("cs_check_ready", byte_ready, 1);
    chk("cs_sum", chk_sum, 32'h3);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    byte_valid = 1'b0;
    chk("cs_match_done", done, 1);
    chk("cs_match_err", err, 0);
    pulse_start();
    chk("cs_sum_cleared", chk_sum, 32'h0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h02, 1);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    byte_valid = 1'b0;
    chk("cs_mismatch_err", err, 1);
    chk("cs_mismatch_done", done, 0);
    chk("cs_mismatch_sum", chk_sum, 32'h3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
